// File: rtl/serial_subtractor_4_if.sv
// serial_subtractor_4_if
//   Handshake and operand/result bundle for the bit-serial subtractor.
//   master : the requester (drives start, a, b; observes busy, done, d, bout)
//   slave  : the subtractor (observes start, a, b; drives busy, done, d, bout)
//   Signals:
//     start  request a new operation (only looked at while busy is low)
//     a, b   unsigned minuend / subtrahend, WIDTH bits
//     busy   bits are being processed
//     done   one-cycle pulse, d/bout freshly updated
//     d      difference a-b modulo 2^WIDTH
//     bout   final borrow, 1 when a < b
interface serial_subtractor_4_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  d,
        input  bout
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output d,
        output bout
    );
endinterface

// File: rtl/serial_subtractor_4.sv
// serial_subtractor_4
//   Bit-serial unsigned subtractor. Computes d = a - b one bit per clock,
//   LSB first, trading latency for a single-bit datapath. Operands are
//   captured when start is accepted; the result and final borrow are held
//   until the next operation completes.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset (wins over start)
//     bus   serial_subtractor_4_if.slave: start/a/b in, busy/done/d/bout out
//   Timing: start accepted at edge E0 -> busy for WIDTH cycles, done pulses
//   in the cycle after edge E(WIDTH). Holding start high in the done cycle
//   launches the next operation back-to-back.
module serial_subtractor_4 #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_subtractor_4_if.slave   bus
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             load;
    logic             step;
    logic             last;

    logic             ai;
    logic             bi;
    logic             di;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    // One-bit full subtractor on the current LSBs. The new difference bit
    // enters the result register from the MSB side so that after WIDTH
    // steps bit 0 has drifted down to position 0.
    always_comb begin
        ai       = a_sh[0];
        bi       = b_sh[0];
        di       = ai ^ bi ^ br;
        br_next  = (~ai & bi) | (~(ai ^ bi) & br);
        res_next = {di, res_sh[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath strobes. DONE accepts start just like IDLE,
    // which is what gives the WIDTH+1 clock back-to-back throughput; start
    // is simply not looked at while shifting.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    last       = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand shift registers, running borrow and bit counter. Operands are
    // copied in on acceptance so later changes on a/b cannot disturb the op.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (step) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            br     <= br_next;
            cnt    <= cnt + CNT_ONE;
        end
    end

    // Visible result. Updated only on the edge that processes the MSB, so
    // the previous answer stays readable for the whole next operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= '0;
            bout_q <= 1'b0;
        end else if (last) begin
            d_q    <= res_next;
            bout_q <= br_next;
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.d    = d_q;
    assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_4.sv
// tb_serial_subtractor_4
//   Self-checking bench for serial_subtractor_4. Expected results come from
//   plain integer arithmetic: d = (a - b) mod 2^WIDTH, bout = (a < b), and
//   done is expected exactly WIDTH clocks after the accepting edge.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor_4;

    localparam int WIDTH = 4;
    localparam int MODV  = 1 << WIDTH;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] held_d;
    logic             held_bout;

    always #5 clk = ~clk;

    serial_subtractor_4_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor_4 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference difference modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] refDiff(input int ra, input int rb);
        return WIDTH'((ra - rb + MODV) % MODV);
    endfunction

    // Reference final borrow.
    function automatic logic refBorrow(input int ra, input int rb);
        return (ra < rb) ? 1'b1 : 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Cycle where the subtractor should be working and the old result held.
    task automatic checkBusyCycle(input string tag);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_d_held"}, 32'(bus.d), 32'(held_d));
        checkOutput({tag, "_bout_held"}, 32'(bus.bout), 32'(held_bout));
    endtask

    // Cycle where nothing is running and the last result is held.
    task automatic checkIdleCycle(input string tag);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_d_held"}, 32'(bus.d), 32'(held_d));
        checkOutput({tag, "_bout_held"}, 32'(bus.bout), 32'(held_bout));
    endtask

    // Completion cycle: done alone, with the freshly computed result.
    task automatic checkDoneCycle(input string tag, input int ra, input int rb);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd1);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_d"}, 32'(bus.d), 32'(refDiff(ra, rb)));
        checkOutput({tag, "_bout"}, 32'(bus.bout), 32'(refBorrow(ra, rb)));
        held_d    = refDiff(ra, rb);
        held_bout = refBorrow(ra, rb);
    endtask

    // One complete operation from idle. With disturb set, a/b are scrambled
    // and start is wiggled while busy; none of that may affect the result.
    task automatic applyStimulus(input int ra, input int rb, input bit disturb);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = WIDTH'(ra);
        bus.b     = WIDTH'(rb);
        @(negedge clk);
        bus.start = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            checkBusyCycle("shift");
            if (disturb) begin
                bus.a     = WIDTH'($urandom);
                bus.b     = WIDTH'($urandom);
                bus.start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        checkDoneCycle("op", ra, rb);
        @(negedge clk);
        checkIdleCycle("after_done");
    endtask

    // Two operations with start held high throughout; a/b switch to the
    // second operands while the first is still shifting.
    task automatic backToBack();
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'b0110;
        bus.b     = 4'b0011;
        @(negedge clk);
        bus.a = 4'b1000;
        bus.b = 4'b0001;
        for (int j = 0; j < WIDTH; j++) begin
            checkBusyCycle("b2b_first");
            @(negedge clk);
        end
        checkDoneCycle("b2b_first", 6, 3);
        @(negedge clk);
        for (int j = 0; j < WIDTH; j++) begin
            checkBusyCycle("b2b_second");
            @(negedge clk);
        end
        checkDoneCycle("b2b_second", 8, 1);
        bus.start = 1'b0;
        @(negedge clk);
        checkIdleCycle("b2b_after");
    endtask

    // Reset two edges after acceptance aborts the op and clears the outputs.
    task automatic resetMidShift();
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'b0101;
        bus.b     = 4'b1100;
        @(negedge clk);
        bus.start = 1'b0;
        checkBusyCycle("abort_pre");
        @(negedge clk);
        checkBusyCycle("abort_pre");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_d", 32'(bus.d), 32'd0);
        checkOutput("abort_bout", 32'(bus.bout), 32'd0);
        held_d    = '0;
        held_bout = 1'b0;
        for (int j = 0; j < WIDTH + 2; j++) begin
            @(negedge clk);
            checkIdleCycle("abort_quiet");
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        held_d    = '0;
        held_bout = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_d", 32'(bus.d), 32'd0);
        checkOutput("reset_bout", 32'(bus.bout), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkIdleCycle("post_reset");

        $display("[TB] directed operations");
        applyStimulus(4'b0111, 4'b0011, 1'b0);
        applyStimulus(4'b0001, 4'b1111, 1'b0);
        applyStimulus(4'b0000, 4'b0001, 1'b0);
        applyStimulus(4'b1111, 4'b1111, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        $display("[TB] back-to-back with start held high");
        backToBack();

        $display("[TB] exhaustive operand sweep with busy-time disturbance");
        for (int ia = 0; ia < MODV; ia++) begin
            for (int ib = 0; ib < MODV; ib++) begin
                applyStimulus(ia, ib, 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] reset during shifting");
        applyStimulus(9, 2, 1'b0);
        resetMidShift();
        applyStimulus(4'b1010, 4'b0110, 1'b0);

        $display("[TB] random operations");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(int'($urandom_range(0, MODV - 1)),
                          int'($urandom_range(0, MODV - 1)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Continuous sanity: done and busy are never asserted together.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checkOutput("busy_and_done", 32'(bus.busy & bus.done), 32'd0);
        end
    end

endmodule
